// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   - OVERSAMPLE:            ticks per bit period
//   - SampleFirst/Mid/Last:  tick indices that are majority-voted for each bit
//   - Err*:                  bit positions inside rx_err / FIFO error field
//   - parity_e:              parity_type encodings
//   - rx_state_e:            receiver FSM states (StBreak only with UART_RX_BREAK_DETECT_EN)
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned SampleFirst = 7;
  localparam int unsigned SampleMid   = 8;
  localparam int unsigned SampleLast  = 9;

  localparam int unsigned ErrW       = 3;
  localparam int unsigned ErrParity  = 0;
  localparam int unsigned ErrFraming = 1;
  localparam int unsigned ErrBreak   = 2;

  typedef enum logic [1:0] {
    ParNone    = 2'b00,
    ParOdd     = 2'b01,
    ParEven    = 2'b10,
    ParNoneAlt = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StStop2
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    StBreak
`endif
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received frames.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_i/wr_data_i: push request and entry; ignored when full unless a pop happens the same clock
//   rd_i          : pop request; ignored when empty
//   rd_data_o     : head entry (valid only while valid_o)
//   valid_o/full_o/count_o : occupancy status
module uart_rx_fifo #(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_i,
  input  logic [Width-1:0]              wr_data_i,
  input  logic                          rd_i,
  output logic [Width-1:0]              rd_data_o,
  output logic                          valid_o,
  output logic                          full_o,
  output logic [$clog2(Depth+1)-1:0]    count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  assign valid_o   = (count_q != '0);
  assign full_o    = (count_q == CntW'(Depth));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = rd_i && valid_o;
    // A pop in the same clock frees the slot, so a full FIFO may still accept.
    wr_en    = wr_i && (!full_o || rd_en);
    wr_ptr_d = wr_ptr_q + AddrW'(wr_en);
    rd_ptr_d = rd_ptr_q + AddrW'(rd_en);
    count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 3-sample majority vote, optional parity,
// one or two stop bits, FWFT receive FIFO with sticky overrun.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   rx, rx_enable           : serial line (idle high), receiver enable
//   divisor                 : clocks per 1/16 bit, minus one
//   parity_type, stop_bits  : frame format
//   rx_data, rx_err         : FIFO head {break, framing, parity}; zero while empty
//   rx_valid, rx_ready      : FIFO not empty / consumer pop
//   overrun, clr_overrun    : sticky dropped-frame flag and its clear
//   active                  : receiver FSM outside idle
//   fifo_count              : occupied FIFO entries
// Build option: define UART_RX_BREAK_DETECT_EN to flag all-zero frames as break
// and hold off until the line returns high.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            rx,
  input  logic                            rx_enable,
  input  logic [DIV_W-1:0]                divisor,
  input  logic [1:0]                      parity_type,
  input  logic                            stop_bits,
  output logic [DATA_W-1:0]               rx_data,
  output logic [ErrW-1:0]                 rx_err,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            overrun,
  input  logic                            clr_overrun,
  output logic                            active,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned SmpW   = $clog2(OVERSAMPLE);
  localparam int unsigned BitW   = $clog2(DATA_W);
  localparam int unsigned EntryW = DATA_W + ErrW;

  // Line synchroniser; rx_prev_q gives the falling-edge reference.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [SmpW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [1:0]         samp_q, samp_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               active_q;
  logic               overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic               zero_q, zero_d;
`endif

  logic               tick, mid_tick, end_tick;
  logic               bit_maj, final_frm, parity_en, exp_par;
  logic               frame_done;
  logic [ErrW-1:0]    frame_err;

  logic               fifo_valid, fifo_full, push, pop;
  logic [EntryW-1:0]  head;

  assign parity_en = (parity_type == ParOdd) || (parity_type == ParEven);
  assign pop       = fifo_valid && rx_ready;
  assign push      = frame_done && (!fifo_full || pop);

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    sample_cnt_d = sample_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
    zero_d       = zero_q;
`endif
    frame_done   = 1'b0;
    frame_err    = '0;
    tick         = 1'b0;

    // Divider is held at reload while idle, so a start edge begins a fresh period.
    if (state_q == StIdle) begin
      div_cnt_d = divisor;
    end else if (div_cnt_q == '0) begin
      tick      = 1'b1;
      div_cnt_d = divisor;
    end else begin
      div_cnt_d = div_cnt_q - DIV_W'(1);
    end

    mid_tick  = tick && (sample_cnt_q == SmpW'(SampleLast));
    end_tick  = tick && (sample_cnt_q == SmpW'(OVERSAMPLE - 1));
    bit_maj   = majority3(samp_q[1], samp_q[0], rx_sync_q);
    final_frm = frm_err_q | ~bit_maj;
    exp_par   = (parity_type == ParOdd) ? ~^shift_q : ^shift_q;

    if (tick) begin
      sample_cnt_d = sample_cnt_q + SmpW'(1);
      if (sample_cnt_q == SmpW'(SampleFirst)) samp_d[1] = rx_sync_q;
      if (sample_cnt_q == SmpW'(SampleMid))   samp_d[0] = rx_sync_q;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    if (mid_tick && bit_maj) zero_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (rx_enable && rx_prev_q && !rx_sync_q) begin
          state_d      = StStart;
          // The edge clock itself is tick 0 of the start bit.
          sample_cnt_d = SmpW'(1);
          bit_cnt_d    = '0;
          par_err_d    = 1'b0;
          frm_err_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d       = 1'b1;
`endif
        end
      end
      StStart: begin
        if (mid_tick && bit_maj) begin
          state_d = StIdle;
        end else if (end_tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mid_tick) shift_d = {bit_maj, shift_q[DATA_W-1:1]};
        if (end_tick) begin
          if (bit_cnt_q == BitW'(DATA_W - 1)) begin
            state_d = parity_en ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (mid_tick) par_err_d = bit_maj ^ exp_par;
        if (end_tick) state_d = StStop;
      end
      StStop: begin
        if (mid_tick) begin
          frm_err_d = final_frm;
          if (!stop_bits) frame_done = 1'b1;
        end
        if (end_tick) state_d = StStop2;
      end
      StStop2: begin
        if (mid_tick) frame_done = 1'b1;
      end
`ifdef UART_RX_BREAK_DETECT_EN
      StBreak: begin
        if (rx_sync_q) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Frame completes half a bit into the last stop bit to resync early.
    if (frame_done) begin
      frame_err[ErrParity]  = par_err_q;
      frame_err[ErrFraming] = final_frm;
      state_d               = StIdle;
`ifdef UART_RX_BREAK_DETECT_EN
      if (zero_q && !bit_maj) begin
        frame_err[ErrBreak]   = 1'b1;
        frame_err[ErrFraming] = 1'b1;
        state_d               = StBreak;
      end
`endif
    end

    if (!rx_enable) begin
      state_d    = StIdle;
      frame_done = 1'b0;
    end
  end

  // Set wins over a same-clock clear.
  assign overrun_d = (frame_done && fifo_full && !pop) | (overrun_q & ~clr_overrun);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      sample_cnt_q <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q       <= 1'b0;
`endif
      active_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q       <= zero_d;
`endif
      active_q     <= (state_d != StIdle);
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .wr_i      (push),
    .wr_data_i ({frame_err, shift_q}),
    .rd_i      (pop),
    .rd_data_o (head),
    .valid_o   (fifo_valid),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  // Head is gated so the outputs read zero whenever the FIFO is empty.
  assign rx_valid = fifo_valid;
  assign rx_data  = fifo_valid ? head[DATA_W-1:0] : '0;
  assign rx_err   = fifo_valid ? head[EntryW-1:DATA_W] : '0;
  assign overrun  = overrun_q;
  assign active   = active_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames
// scored against a frame-level model (queue of expected {err, data} entries).
module tb_uart_rx_core;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;
  localparam int DIV   = 3;
  localparam int BIT   = 16 * (DIV + 1);
  localparam int CW    = $clog2(DEPTH + 1);
  // Clocks from the start-edge clock to the final-stop tick-9 sample, 8N1.
  localparam int WR_OFS = (DIV + 1) * (16 * 9 + 9);

  logic            clock = 1'b0;
  logic            reset_n;
  logic            rx;
  logic            rx_enable;
  logic [DIVW-1:0] divisor;
  logic [1:0]      parity_type;
  logic            stop_bits;
  logic [DW-1:0]   rx_data;
  logic [2:0]      rx_err;
  logic            rx_valid;
  logic            rx_ready;
  logic            overrun;
  logic            clr_overrun;
  logic            active;
  logic [CW-1:0]   fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW+2:0] exp_q[$];
  logic          exp_ovr = 1'b0;

  always #5 clock = ~clock;

  uart_rx_core #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIVW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_enable   (rx_enable),
    .divisor     (divisor),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .active      (active),
    .fifo_count  (fifo_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected FIFO entry for a frame, from the line-level bit values.
  function automatic logic [DW+2:0] model_entry(input logic [DW-1:0] d, input logic [1:0] pt,
                                                input logic sb, input logic pbit,
                                                input logic s1, input logic s2);
    int   ones;
    logic pe, fe;
    ones = $countones(d);
    pe   = 1'b0;
    if (pt == 2'b01) pe = ((ones + int'(pbit)) % 2) == 0;
    else if (pt == 2'b10) pe = ((ones + int'(pbit)) % 2) == 1;
    fe = !s1 || (sb && !s2);
`ifdef UART_RX_BREAK_DETECT_EN
    if ((d == '0) && !((pt == 2'b01 || pt == 2'b10) && pbit) && !s1 && !(sb && s2))
      return {1'b1, 1'b1, pe, d};
`endif
    return {1'b0, fe, pe, d};
  endfunction

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic s1,
                            input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (parity_type == 2'b01 || parity_type == 2'b10) send_bit(pbit);
    send_bit(s1);
    if (stop_bits) send_bit(s2);
    rx = 1'b1;
    repeat (16) @(negedge clock);
  endtask

  task automatic frame_and_model(input logic [DW-1:0] d, input logic pbit, input logic s1,
                                 input logic s2);
    logic [DW+2:0] e;
    e = model_entry(d, parity_type, stop_bits, pbit, s1, s2);
    send_frame(d, pbit, s1, s2);
    if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic pop_one();
    @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    check_eq({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    if (exp_q.size() > 0) check_eq({tag, "_head"}, 32'({rx_err, rx_data}), 32'(exp_q[0]));
    else check_eq({tag, "_head"}, 32'({rx_err, rx_data}), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'd0);
    check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
    check_eq({tag, "_active"}, 32'(active), 32'd0);
    check_eq({tag, "_data"}, 32'(rx_data), 32'd0);
    check_eq({tag, "_err"}, 32'(rx_err), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) if (exp_q.size() > 0) begin
      check_state("drain");
      pop_one();
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic          pbit, s1, s2, seen;

    reset_n     = 1'b0;
    rx          = 1'b1;
    rx_enable   = 1'b1;
    divisor     = DIVW'(DIV);
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    rx_ready    = 1'b0;
    clr_overrun = 1'b0;
    repeat (5) @(negedge clock);
    check_reset("por");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 8N1 0xA5
    frame_and_model(8'hA5, 1'b0, 1'b1, 1'b1);
    check_eq("a5_valid", 32'(rx_valid), 32'd1);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_err", 32'(rx_err), 32'd0);
    check_eq("a5_count", 32'(fifo_count), 32'd1);
    pop_one();
    check_eq("a5_popped", 32'(rx_valid), 32'd0);

    // Even parity, 0x07 with parity bit 0
    parity_type = 2'b10;
    frame_and_model(8'h07, 1'b0, 1'b1, 1'b1);
    check_eq("par_data", 32'(rx_data), 32'h07);
    check_eq("par_err", 32'(rx_err), 32'b001);
    pop_one();

    // Two stop bits, second one low
    parity_type = 2'b00;
    stop_bits   = 1'b1;
    frame_and_model(8'h5A, 1'b0, 1'b1, 1'b0);
    check_eq("stop2_data", 32'(rx_data), 32'h5A);
    check_eq("stop2_err", 32'(rx_err), 32'b010);
    pop_one();
    stop_bits = 1'b0;

    // Short glitch in idle
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    check_eq("glitch_count", 32'(fifo_count), 32'd0);
    check_eq("glitch_active", 32'(active), 32'd0);

    // Randomized frames against the scoreboard
    for (int it = 0; it < 14; it++) begin
      parity_type = 2'($urandom_range(0, 3));
      stop_bits   = 1'($urandom_range(0, 1));
      d           = DW'($urandom);
      pbit        = 1'($urandom_range(0, 1));
      s1          = ($urandom_range(0, 4) != 0);
      s2          = ($urandom_range(0, 4) != 0);
      frame_and_model(d, pbit, s1, s2);
      check_state("rnd");
      check_eq("rnd_active", 32'(active), 32'd0);
      if ($urandom_range(0, 1) == 1) pop_one();
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        clr_overrun = 1'b1;
        @(negedge clock);
        clr_overrun = 1'b0;
        exp_ovr = 1'b0;
        check_eq("rnd_clr", 32'(overrun), 32'd0);
      end
    end
    drain();
    @(negedge clock);
    clr_overrun = 1'b1;
    @(negedge clock);
    clr_overrun = 1'b0;
    exp_ovr     = 1'b0;
    check_state("drained");

    // Overflow: five frames, no pops
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    for (int k = 0; k < 5; k++) frame_and_model(DW'(8'h11 * (k + 1)), 1'b0, 1'b1, 1'b1);
    check_eq("ovf_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_flag", 32'(overrun), 32'd1);
    check_eq("ovf_head", 32'(rx_data), 32'h11);
    drain();
    check_state("ovf_empty");
    @(negedge clock);
    clr_overrun = 1'b1;
    @(negedge clock);
    clr_overrun = 1'b0;
    exp_ovr     = 1'b0;

    // Pop on the very clock of the fifth write
    for (int k = 0; k < 4; k++) frame_and_model(DW'(8'h21 + k), 1'b0, 1'b1, 1'b1);
    check_eq("pow_full", 32'(fifo_count), 32'd4);
    seen = 1'b0;
    fork
      frame_and_model(8'hC3, 1'b0, 1'b1, 1'b1);
      begin
        for (int c = 0; c < 100 && !seen; c++) begin
          @(posedge clock);
          #1;
          if (active) seen = 1'b1;
        end
        repeat (WR_OFS - 1) @(posedge clock);
        @(negedge clock);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        void'(exp_q.pop_front());
      end
    join
    check_eq("pow_start_seen", 32'(seen), 32'd1);
    check_eq("pow_ovr", 32'(overrun), 32'd0);
    check_eq("pow_count", 32'(fifo_count), 32'd4);
    drain();

    // rx_enable drop mid-frame
    frame_and_model(8'h96, 1'b0, 1'b1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_enable = 1'b0;
    @(negedge clock);
    check_eq("dis_active", 32'(active), 32'd0);
    rx = 1'b1;
    repeat (BIT) @(negedge clock);
    check_state("dis_kept");
    rx_enable = 1'b1;
    repeat (BIT) @(negedge clock);
    check_state("dis_after");

    // Reset in the middle of the data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    #1;
    check_reset("mid");
    exp_q.delete();
    exp_ovr = 1'b0;
    rx      = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (BIT) @(negedge clock);
    frame_and_model(8'h3C, 1'b0, 1'b1, 1'b1);
    check_eq("rst_data", 32'(rx_data), 32'h3C);
    check_eq("rst_err", 32'(rx_err), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd1);
    pop_one();

    // Long low line (20 bit times)
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clock);
    rx = 1'b1;
    repeat (BIT) @(negedge clock);
    exp_q.push_back(model_entry('0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    check_state("brk");
    check_eq("brk_active", 32'(active), 32'd0);
`ifdef UART_RX_BREAK_DETECT_EN
    check_eq("brk_err", 32'(rx_err), 32'b110);
`else
    check_eq("brk_err", 32'(rx_err), 32'b010);
`endif
    pop_one();
    check_eq("brk_empty", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
